// File: rtl/conv_sequencer_fsm_pkg.sv
// Shared constants and state type for the conv sequencer.
package conv_sequencer_fsm_pkg;

  localparam int unsigned DefAddrW   = 10;  // row address width
  localparam int unsigned DefNBanks  = 3;   // column buffers
  localparam int unsigned DefConvLat = 2;   // conv input valid -> result valid
  localparam int unsigned KernelW    = 3;   // kernel width/height

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StFlush = 3'd3,
    StOut   = 3'd4
  } state_e;

endpackage

// File: rtl/conv_sequencer_fsm_if.sv
// Memory-side bus of the conv sequencer: column buffers, conv input and result memory.
interface conv_sequencer_fsm_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned N_BANKS = 3
);
  logic [N_BANKS-1:0] mem_we;
  logic [ADDR_W-1:0]  mem_wr_addr;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic               conv_valid;
  logic               res_we;
  logic [ADDR_W-1:0]  res_wr_addr;
  logic [ADDR_W-1:0]  res_rd_addr;

  modport master (
    output mem_we, mem_wr_addr, mem_rd_addr, conv_valid, res_we, res_wr_addr, res_rd_addr
  );

  modport slave (
    input mem_we, mem_wr_addr, mem_rd_addr, conv_valid, res_we, res_wr_addr, res_rd_addr
  );
endinterface

// File: rtl/conv_valid_pipe.sv
// Shift register carrying {valid, row} alongside the BRAM read and conv core latency.
module conv_valid_pipe #(
  parameter int unsigned Depth = 3,
  parameter int unsigned RowW  = 10
) (
  input  logic            i_CLK,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic            i_valid,
  input  logic [RowW-1:0] i_row,
  output logic            o_first_valid,
  output logic            o_valid,
  output logic [RowW-1:0] o_row
);

  logic [Depth-1:0]           valid_q;
  logic [Depth-1:0][RowW-1:0] row_q;

  // Shift stage; a clear drops everything in flight so no stale result gets written.
  always_ff @(posedge i_CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      row_q   <= '0;
    end else if (i_clr) begin
      valid_q <= '0;
    end else begin
      valid_q <= {valid_q[Depth-2:0], i_valid};
      row_q   <= {row_q[Depth-2:0], i_row};
    end
  end

  assign o_first_valid = valid_q[0];
  assign o_valid       = valid_q[Depth-1];
  assign o_row         = row_q[Depth-1];

endmodule

// File: rtl/conv_sequencer_fsm.sv
// Sequences column-buffer loading, the row sweep through the conv core and result readout.
module conv_sequencer_fsm
  import conv_sequencer_fsm_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned N_BANKS  = DefNBanks,
  parameter int unsigned CONV_LAT = DefConvLat
) (
  input  logic                 i_CLK,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic                 i_run,
  input  logic                 i_valid,
  input  logic [ADDR_W-1:0]    i_imgLength,
  conv_sequencer_fsm_if.master mem_bus,
  output logic                 o_EOP,
  output logic                 o_load_full,
  output logic [2:0]           o_state
);

  localparam int unsigned BankW = $clog2(N_BANKS + 1);
  localparam int unsigned CntW  = $clog2(CONV_LAT + 2);

  localparam logic [BankW-1:0]  BankFull  = BankW'(N_BANKS);
  localparam logic [CntW-1:0]   FlushLast = CntW'(CONV_LAT);
  localparam logic [ADDR_W-1:0] One       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] Kw        = ADDR_W'(KernelW);
  localparam logic [ADDR_W-1:0] KwM1      = ADDR_W'(KernelW - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0]  wr_row_q, wr_row_d;
  logic [ADDR_W-1:0]  rd_row_q, rd_row_d;
  logic [ADDR_W-1:0]  res_rd_q, res_rd_d;
  logic [ADDR_W-1:0]  mem_wr_addr_q, mem_wr_addr_d;
  logic [N_BANKS-1:0] mem_we_q, mem_we_d;
  logic [BankW-1:0]   bank_q, bank_d;
  logic [CntW-1:0]    flush_q, flush_d;
  logic               full_q, full_d;
  logic               eop_q, eop_d;
  logic               issue, pipe_clr;
  logic               pipe_valid;
  logic [ADDR_W-1:0]  pipe_row;

  // State and counter registers.
  always_ff @(posedge i_CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      len_q         <= One;
      wr_row_q      <= '0;
      rd_row_q      <= '0;
      res_rd_q      <= '0;
      mem_wr_addr_q <= '0;
      mem_we_q      <= '0;
      bank_q        <= '0;
      flush_q       <= '0;
      full_q        <= 1'b0;
      eop_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      wr_row_q      <= wr_row_d;
      rd_row_q      <= rd_row_d;
      res_rd_q      <= res_rd_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_we_q      <= mem_we_d;
      bank_q        <= bank_d;
      flush_q       <= flush_d;
      full_q        <= full_d;
      eop_q         <= eop_d;
    end
  end

  // Next-state and counter updates; i_load overrides everything else in its cycle.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    wr_row_d      = wr_row_q;
    rd_row_d      = rd_row_q;
    res_rd_d      = res_rd_q;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_we_d      = '0;
    bank_d        = bank_q;
    flush_d       = flush_q;
    full_d        = full_q;
    eop_d         = eop_q;
    issue         = 1'b0;
    pipe_clr      = 1'b0;
    if (i_load) begin
      state_d  = StLoad;
      len_d    = (i_imgLength == '0) ? One : i_imgLength;
      wr_row_d = '0;
      rd_row_d = '0;
      res_rd_d = '0;
      bank_d   = '0;
      flush_d  = '0;
      full_d   = 1'b0;
      eop_d    = 1'b0;
      pipe_clr = 1'b1;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (i_valid) begin
            if (bank_q == BankFull) begin
              full_d = 1'b1;
            end else begin
              mem_we_d      = N_BANKS'(1) << bank_q;
              mem_wr_addr_d = wr_row_q;
              if (wr_row_q == len_q - One) begin
                wr_row_d = '0;
                bank_d   = bank_q + BankW'(1);
              end else begin
                wr_row_d = wr_row_q + One;
              end
            end
          end
          if (i_run) begin
            state_d  = StRun;
            rd_row_d = '0;
          end
        end
        StRun: begin
          issue = 1'b1;
          if (rd_row_q == len_q - One) begin
            rd_row_d = '0;
            flush_d  = '0;
            state_d  = StFlush;
          end else begin
            rd_row_d = rd_row_q + One;
          end
        end
        StFlush: begin
          // Last issued row leaves the pipeline after 1+CONV_LAT cycles.
          if (flush_q == FlushLast) begin
            flush_d = '0;
            eop_d   = 1'b1;
            state_d = StOut;
          end else begin
            flush_d = flush_q + CntW'(1);
          end
        end
        StOut: begin
          if (i_valid) begin
            // Short images produce no results, so the read pointer stays at 0.
            if (len_q <= Kw || res_rd_q >= len_q - Kw) begin
              res_rd_d = '0;
            end else begin
              res_rd_d = res_rd_q + One;
            end
          end
        end
        default: ;
      endcase
    end
  end

  conv_valid_pipe #(
    .Depth (1 + CONV_LAT),
    .RowW  (ADDR_W)
  ) u_valid_pipe (
    .i_CLK         (i_CLK),
    .i_rst_n       (i_rst_n),
    .i_clr         (pipe_clr),
    .i_valid       (issue),
    .i_row         (rd_row_q),
    .o_first_valid (mem_bus.conv_valid),
    .o_valid       (pipe_valid),
    .o_row         (pipe_row)
  );

  // Only rows with a full kernel window above them yield a result.
  always_comb begin
    mem_bus.res_we      = pipe_valid && (pipe_row >= KwM1);
    mem_bus.res_wr_addr = mem_bus.res_we ? (pipe_row - KwM1) : '0;
  end

  assign mem_bus.mem_we      = mem_we_q;
  assign mem_bus.mem_wr_addr = mem_wr_addr_q;
  assign mem_bus.mem_rd_addr = rd_row_q;
  assign mem_bus.res_rd_addr = res_rd_q;
  assign o_EOP               = eop_q;
  assign o_load_full         = full_q;
  assign o_state             = state_q;

endmodule
